voice_allocator: RTL and testbench

Polyphonic voice scheduler for the 24-key keyboard front end. Detects press and release edges on the debounced `keys` vector and shares a fixed pool of tone-generator voices among the pressed keys. When all voices are busy, the oldest allocation is stolen. Sits between the keyboard scan and the tone generators; the newest-key/one-hot display path is unaffected.

---
 rtl/voice_pkg.sv | 19 +
 rtl/prio_enc.sv | 22 ++
 rtl/voice_allocator.sv | 159 +++++++++++++++
 tb/tb_voice_allocator.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared defaults and helper types for the polyphonic voice allocator.
package voice_pkg;

  localparam int DEFAULT_NUM_KEYS   = 24;
  localparam int DEFAULT_NUM_VOICES = 4;
  localparam int DEFAULT_KEY_W      = 5;

  // Age rank width for the default voice pool.
  localparam int AGE_W = $clog2(DEFAULT_NUM_VOICES);

  typedef logic [DEFAULT_KEY_W-1:0] key_idx_t;
  typedef logic [AGE_W-1:0]         age_t;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module prio_enc
  import voice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: queues key press/release edges and shares a
// fixed pool of voices among held keys, stealing the oldest voice when full.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_KEYS   = DEFAULT_NUM_KEYS,
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int KEY_W      = DEFAULT_KEY_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES-1:0]       voice_start,
  output logic                        steal,
  output logic                        busy
);

  localparam int KI_W = idx_width(NUM_KEYS);
  localparam int VI_W = idx_width(NUM_VOICES);
  localparam int AW   = idx_width(NUM_VOICES);

  // Registered state
  logic [NUM_KEYS-1:0]   prev_q,  prev_d;
  logic [NUM_KEYS-1:0]   press_q, press_d;
  logic [NUM_KEYS-1:0]   rel_q,   rel_d;
  logic [KEY_W-1:0]      key_q    [NUM_VOICES];
  logic [KEY_W-1:0]      key_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] start_q,  start_d;
  logic                  steal_q,  steal_d;
  logic [AW-1:0]         age_q    [NUM_VOICES];
  logic [AW-1:0]         age_d    [NUM_VOICES];

  // Service selection
  logic [NUM_KEYS-1:0]   rise, fall;
  logic [NUM_VOICES-1:0] free_mask;
  logic [KI_W-1:0]       rel_idx, press_idx;
  logic                  rel_valid, press_valid;
  logic [VI_W-1:0]       free_idx, victim, alloc;
  logic                  free_valid;

  assign free_mask = ~active_q;

  prio_enc #(.WIDTH(NUM_KEYS), .IDX_W(KI_W)) u_rel_enc (
    .req   (rel_q),
    .idx   (rel_idx),
    .valid (rel_valid)
  );

  prio_enc #(.WIDTH(NUM_KEYS), .IDX_W(KI_W)) u_press_enc (
    .req   (press_q),
    .idx   (press_idx),
    .valid (press_valid)
  );

  prio_enc #(.WIDTH(NUM_VOICES), .IDX_W(VI_W)) u_free_enc (
    .req   (free_mask),
    .idx   (free_idx),
    .valid (free_valid)
  );

  // Service one pending event (release first), then fold in this cycle's edges.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    rise     = keys & ~prev_q;
    fall     = ~keys & prev_q;
    prev_d   = keys;
    press_d  = press_q;
    rel_d    = rel_q;
    key_d    = key_q;
    active_d = active_q;
    start_d  = '0;
    steal_d  = 1'b0;
    age_d    = age_q;
    victim   = '0;

    // The oldest voice carries the highest age rank.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (age_q[v] == AW'(NUM_VOICES - 1)) victim = VI_W'(v);
    end
    alloc = free_valid ? free_idx : victim;

    if (rel_valid) begin
      rel_d[rel_idx] = 1'b0;
      // A stolen key matches nothing, so its release is silently dropped.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (active_q[v] && key_q[v] == KEY_W'(rel_idx)) active_d[v] = 1'b0;
      end
    end else if (press_valid) begin
      press_d[press_idx] = 1'b0;
      key_d[alloc]       = KEY_W'(press_idx);
      active_d[alloc]    = 1'b1;
      start_d[alloc]     = 1'b1;
      steal_d            = ~free_valid;
      // Voices younger than the chosen one age by one; the chosen one becomes newest.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (age_q[v] < age_q[alloc]) age_d[v] = age_q[v] + 1'b1;
      end
      age_d[alloc] = '0;
    end

    // Edges act on the post-service masks, so a key whose press is being
    // allocated right now still queues its release if it falls this cycle.
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) begin
        press_d[i] = 1'b1;
        rel_d[i]   = 1'b0;
      end else if (fall[i]) begin
        if (press_d[i]) press_d[i] = 1'b0;
        else            rel_d[i]   = 1'b1;
      end
    end
  end

  // Single state register for edge history, pending masks and the voice pool.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      active_q <= '0;
      start_q  <= '0;
      steal_q  <= 1'b0;
      // NOTE: the voice tables are a handful of flops, not RAM, so resetting
      // them is cheap and gives the age ranks their required start permutation.
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        age_q[v] <= AW'(v);
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prev_q   <= prev_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      active_q <= active_d;
      start_q  <= start_d;
      steal_q  <= steal_d;
      key_q    <= key_d;
      age_q    <= age_d;
    end
  end

  // Flatten the per-voice key table onto the output bus.
  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KEY_W +: KEY_W] = key_q[v];
    end
  end

  assign voice_active = active_q;
  assign voice_start  = start_q;
  assign steal        = steal_q;
  assign busy         = |(press_q | rel_q);

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a queue/array reference model predicts
// each visible allocation or release, and a monitor checks them as they appear.
module tb_voice_allocator;
  import voice_pkg::*;

  localparam int NK = DEFAULT_NUM_KEYS;
  localparam int NV = DEFAULT_NUM_VOICES;
  localparam int KW = DEFAULT_KEY_W;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NK-1:0]     keys  = '0;
  logic [NV*KW-1:0]  voice_key;
  logic [NV-1:0]     voice_active;
  logic [NV-1:0]     voice_start;
  logic              steal;
  logic              busy;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keys         (keys),
    .voice_key    (voice_key),
    .voice_active (voice_active),
    .voice_start  (voice_start),
    .steal        (steal),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              at;
    logic [NV-1:0]   start;
    logic            stl;
    logic [NV-1:0]   active;
    logic [NV*KW-1:0] vkeys;
  } exp_t;

  exp_t sb[$];

  // Reference model: sets of pending keys, voice table, and a recency list
  // (front = most recently allocated voice, back = oldest).
  logic [NK-1:0] m_prev, m_press, m_rel;
  int            m_key [NV];
  bit            m_act [NV];
  int            lru   [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int vk(input int v);
    return int'(voice_key[v*KW +: KW]);
  endfunction

  function automatic bit model_busy();
    return |(m_press | m_rel);
  endfunction

  task automatic model_reset();
    m_prev  = '0;
    m_press = '0;
    m_rel   = '0;
    lru.delete();
    for (int v = 0; v < NV; v++) begin
      m_key[v] = 0;
      m_act[v] = 1'b0;
      lru.push_back(v);
    end
  endtask

  task automatic push_exp(input int at, input logic [NV-1:0] start, input logic stl);
    exp_t e;
    e.at    = at;
    e.start = start;
    e.stl   = stl;
    for (int v = 0; v < NV; v++) begin
      e.active[v]          = m_act[v];
      e.vkeys[v*KW +: KW]  = KW'(m_key[v]);
    end
    sb.push_back(e);
  endtask

  // Advance the model across one clock edge that samples keys value k.
  task automatic model_step(input logic [NK-1:0] k, input int at);
    int  sel;
    int  vsel;
    bit  matched;
    bit  stl;
    sel = -1;
    for (int i = 0; i < NK; i++) if (m_rel[i]) begin sel = i; break; end
    if (sel >= 0) begin
      m_rel[sel] = 1'b0;
      matched = 1'b0;
      for (int v = 0; v < NV; v++) begin
        if (m_act[v] && m_key[v] == sel) begin
          m_act[v] = 1'b0;
          matched  = 1'b1;
        end
      end
      if (matched) push_exp(at, '0, 1'b0);
    end else begin
      for (int i = 0; i < NK; i++) if (m_press[i]) begin sel = i; break; end
      if (sel >= 0) begin
        m_press[sel] = 1'b0;
        vsel = -1;
        for (int v = 0; v < NV; v++) if (!m_act[v]) begin vsel = v; break; end
        stl = (vsel < 0);
        if (stl) vsel = lru[lru.size()-1];
        for (int j = 0; j < lru.size(); j++) begin
          if (lru[j] == vsel) begin
            lru.delete(j);
            break;
          end
        end
        lru.push_front(vsel);
        m_key[vsel] = sel;
        m_act[vsel] = 1'b1;
        push_exp(at, NV'(1) << vsel, stl);
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (k[i] && !m_prev[i]) begin
        m_press[i] = 1'b1;
        m_rel[i]   = 1'b0;
      end else if (!k[i] && m_prev[i]) begin
        if (m_press[i]) m_press[i] = 1'b0;
        else            m_rel[i]   = 1'b1;
      end
    end
    m_prev = k;
  endtask

  task automatic drive(input logic [NK-1:0] k);
    @(negedge clk);
    check("busy", busy, model_busy());
    keys = k;
    model_step(k, cyc + 1);
  endtask

  task automatic do_reset(input logic [NK-1:0] held);
    @(negedge clk);
    rst_n = 1'b0;
    keys  = held;
    #1;
    check("rst_active", voice_active, '0);
    check("rst_start", voice_start, '0);
    check("rst_steal", steal, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_keys", voice_key, '0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_step(held, cyc + 1);
  endtask

  // Monitor: pop and compare whenever the DUT shows an allocation or release.
  initial begin : monitor
    logic [NV-1:0] last_act;
    exp_t          e;
    last_act = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_act = voice_active;
      end else begin
        if (voice_start != '0 || voice_active != last_act) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: start=%b active=%b steal=%b, none expected (cycle %0d)",
                     voice_start, voice_active, steal, cyc);
          end else begin
            e = sb.pop_front();
            check("event_cycle", cyc, e.at);
            check("voice_start", voice_start, e.start);
            check("steal", steal, e.stl);
            check("voice_active", voice_active, e.active);
            check("voice_key", voice_key, e.vkeys);
          end
        end else if (sb.size() > 0 && sb[0].at <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_output: got no event, expected start=%b active=%b at cycle %0d",
                   sb[0].start, sb[0].active, sb[0].at);
          e = sb.pop_front();
        end else if (steal) begin
          checks++;
          errors++;
          $display("FAIL stray_steal: got steal=1 expected 0 (cycle %0d)", cyc);
        end
        last_act = voice_active;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [NK-1:0] k;
    int            bc;
    int            found;
    int            bound;
    model_reset();

    // Single press of key 3.
    do_reset('0);
    k = NK'(1) << 3;
    repeat (3) drive(k);
    check("t1_active", voice_active, 4'b0001);
    check("t1_key0", vk(0), 3);

    // Simultaneous presses 5, 7, 9: busy for exactly three cycles.
    do_reset('0);
    k = (NK'(1) << 5) | (NK'(1) << 7) | (NK'(1) << 9);
    drive(k);
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(k);
      if (busy) bc++;
    end
    check("t2_busy_cycles", bc, 3);
    check("t2_key0", vk(0), 5);
    check("t2_key1", vk(1), 7);
    check("t2_key2", vk(2), 9);

    // Fill the pool with 1..4, steal with 10, release stolen key 1, steal with 11.
    do_reset('0);
    k = '0;
    for (int i = 1; i <= 4; i++) begin
      k[i] = 1'b1;
      repeat (2) drive(k);
    end
    k[10] = 1'b1;
    repeat (3) drive(k);
    check("t3_steal_v0", vk(0), 10);
    k[1] = 1'b0;
    repeat (3) drive(k);
    check("t3_after_rel", voice_active, 4'b1111);
    k[11] = 1'b1;
    repeat (3) drive(k);
    check("t3_steal_v1", vk(1), 11);

    // Key 8 pressed and released while four lower presses are queued.
    do_reset('0);
    k = NK'(4'hF) | (NK'(1) << 8);
    drive(k);
    k = NK'(4'hF);
    repeat (7) drive(k);
    found = 0;
    for (int v = 0; v < NV; v++) if (vk(v) == 8) found++;
    check("t4_key8_absent", found, 0);

    // Release 3 and press 12 together with a full pool: release goes first.
    do_reset('0);
    k = '0;
    for (int i = 1; i <= 4; i++) begin
      k[i] = 1'b1;
      repeat (2) drive(k);
    end
    k[3]  = 1'b0;
    k[12] = 1'b1;
    repeat (4) drive(k);
    check("t5_v2_key", vk(2), 12);
    check("t5_active", voice_active, 4'b1111);

    // Reset with events pending; keys 2 and 6 held across reset release.
    do_reset('0);
    k = NK'(16'hFF) << 10;
    repeat (2) drive(k);
    k = (NK'(1) << 2) | (NK'(1) << 6);
    do_reset(k);
    repeat (4) drive(k);
    check("t6_key0", vk(0), 2);
    check("t6_key1", vk(1), 6);
    check("t6_active", voice_active, 4'b0011);

    // Random key activity against the model.
    do_reset('0);
    k = '0;
    for (int n = 0; n < 1500; n++) begin
      repeat ($urandom_range(0, 2)) k[$urandom_range(0, NK - 1)] ^= 1'b1;
      drive(k);
    end

    // Drain the pending events.
    bound = 0;
    while (model_busy() && bound < 200) begin
      drive(k);
      bound++;
    end
    if (bound >= 200) check("drain_timeout", bound, 0);
    repeat (3) drive(k);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
